// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and helpers for the weighted round-robin arbiter
package arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // A programmed weight of zero still grants one burst per turn.
    function automatic logic [31:0] weight_to_cnt(input logic [31:0] w);
        return (w == 32'd0) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority picker (first set bit after ptr)
module rr_pick
    import arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     winner_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    logic [IDX_W-1:0] start;
    logic [2*N-1:0]   rot;
    int               off;

    // Rotate a doubled request vector so the scan starts at ptr+1, then take the lowest set bit.
    always_comb begin
        start    = (ptr_i == IDX_W'(N - 1)) ? '0 : ptr_i + IDX_W'(1);
        rot      = {req_i, req_i} >> start;
        off      = 0;
        found_o  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off     = i;
                found_o = 1'b1;
            end
        end
        idx_o    = IDX_W'((int'(start) + off) % N);
        winner_o = found_o ? (N'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/wrr_arbiter.sv
// rtl/wrr_arbiter.sv - weighted round-robin arbiter with burst locking and zero-bubble handoff
module wrr_arbiter
    import arb_pkg::*;
#(
    parameter int  NUM_REQUESTERS = 4,
    parameter int  WEIGHT_W       = 4,
    localparam int IDX_W          = $clog2(NUM_REQUESTERS)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQUESTERS-1:0]          i_requests,
    input  logic [NUM_REQUESTERS*WEIGHT_W-1:0] i_weights,
    input  logic                               i_ready,
    input  logic                               i_last,
    output logic [NUM_REQUESTERS-1:0]          o_grants,
    output logic [IDX_W-1:0]                   o_grant_idx,
    output logic                               o_grant_valid
);

    arb_state_e                state_q, state_d;
    logic [NUM_REQUESTERS-1:0] grants_q, grants_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [IDX_W-1:0]          ptr_q, ptr_d;
    logic [WEIGHT_W-1:0]       cnt_q, cnt_d;
    logic                      in_burst_q, in_burst_d;

    logic                      granted;
    logic                      beat;
    logic                      burst_end;
    logic                      release_now;
    logic [IDX_W-1:0]          pick_ptr;
    logic [NUM_REQUESTERS-1:0] pick_onehot;
    logic [IDX_W-1:0]          pick_idx;
    logic                      pick_found;
    logic [WEIGHT_W-1:0]       weight_sel;
    logic [WEIGHT_W-1:0]       load_cnt;

    assign granted     = (state_q == ARB_GRANT);
    assign beat        = granted & i_ready & i_requests[idx_q];
    assign burst_end   = beat & i_last;
    assign release_now = granted & ((burst_end & (cnt_q == WEIGHT_W'(1)))
                                    | (~in_burst_q & ~i_requests[idx_q]));
    // On release the outgoing grantee becomes the rotation origin, so it is picked last.
    assign pick_ptr    = release_now ? idx_q : ptr_q;

    rr_pick #(
        .N     (NUM_REQUESTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i    (i_requests),
        .ptr_i    (pick_ptr),
        .winner_o (pick_onehot),
        .idx_o    (pick_idx),
        .found_o  (pick_found)
    );

    // Select the winner's weight field and convert it to a burst count.
    always_comb begin
        weight_sel = '0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            if (pick_idx == IDX_W'(k)) begin
                weight_sel = i_weights[k*WEIGHT_W +: WEIGHT_W];
            end
        end
        load_cnt = WEIGHT_W'(weight_to_cnt(32'(weight_sel)));
    end

    // Next-state: load a new grant from IDLE or on release, otherwise track bursts of the holder.
    always_comb begin
        state_d    = state_q;
        grants_d   = grants_q;
        idx_d      = idx_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        in_burst_d = in_burst_q;
        if (!granted || release_now) begin
            if (release_now) begin
                ptr_d = idx_q;
            end
            in_burst_d = 1'b0;
            if (pick_found) begin
                state_d  = ARB_GRANT;
                grants_d = pick_onehot;
                idx_d    = pick_idx;
                cnt_d    = load_cnt;
            end else begin
                state_d  = ARB_IDLE;
                grants_d = '0;
                idx_d    = '0;
                cnt_d    = '0;
            end
        end else if (burst_end) begin
            in_burst_d = 1'b0;
            if (cnt_q != '0) begin
                cnt_d = cnt_q - WEIGHT_W'(1);
            end
        end else if (beat) begin
            in_burst_d = 1'b1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            grants_q   <= '0;
            idx_q      <= '0;
            ptr_q      <= IDX_W'(NUM_REQUESTERS - 1);
            cnt_q      <= '0;
            in_burst_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grants_q   <= grants_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            in_burst_q <= in_burst_d;
        end
    end

    assign o_grants      = grants_q;
    assign o_grant_idx   = idx_q;
    assign o_grant_valid = |grants_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// tb/tb_wrr_arbiter.sv - directed table-driven bench for wrr_arbiter
module tb_wrr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  i_requests;
    logic [15:0] i_weights;
    logic        i_ready;
    logic        i_last;
    logic [3:0]  o_grants;
    logic [1:0]  o_grant_idx;
    logic        o_grant_valid;

    int n_cmp = 0;
    int n_bad = 0;

    wrr_arbiter #(
        .NUM_REQUESTERS (4),
        .WEIGHT_W       (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_requests    (i_requests),
        .i_weights     (i_weights),
        .i_ready       (i_ready),
        .i_last        (i_last),
        .o_grants      (o_grants),
        .o_grant_idx   (o_grant_idx),
        .o_grant_valid (o_grant_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [15:0] w;
        logic        ready;
        logic        last;
        logic [3:0]  exp_g;
        logic [1:0]  exp_idx;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [3:0] exp_g, input logic [1:0] exp_idx);
        n_cmp++;
        if (o_grants !== exp_g) begin
            n_bad++;
            $display("FAIL %s grants: got %b expected %b", name, o_grants, exp_g);
        end
        n_cmp++;
        if (o_grant_valid !== (|exp_g)) begin
            n_bad++;
            $display("FAIL %s valid: got %b expected %b", name, o_grant_valid, |exp_g);
        end
        if (|exp_g) begin
            n_cmp++;
            if (o_grant_idx !== exp_idx) begin
                n_bad++;
                $display("FAIL %s idx: got %0d expected %0d", name, o_grant_idx, exp_idx);
            end
        end
    endtask

    task automatic step(input logic r, input logic [3:0] req, input logic rdy, input logic lst);
        @(negedge clk);
        rst        = r;
        i_requests = req;
        i_ready    = rdy;
        i_last     = lst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; i_requests = '0; i_weights = 16'h1111; i_ready = 1'b0; i_last = 1'b0;

        // alternating pair, weights 1
        vecs[0]  = '{1'b1, 4'b0000, 16'h1111, 1'b0, 1'b0, 4'b0000, 2'd0};
        vecs[1]  = '{1'b0, 4'b0101, 16'h1111, 1'b1, 1'b1, 4'b0001, 2'd0};
        vecs[2]  = '{1'b0, 4'b0101, 16'h1111, 1'b1, 1'b1, 4'b0100, 2'd2};
        vecs[3]  = '{1'b0, 4'b0101, 16'h1111, 1'b1, 1'b1, 4'b0001, 2'd0};
        vecs[4]  = '{1'b0, 4'b0101, 16'h1111, 1'b1, 1'b1, 4'b0100, 2'd2};
        vecs[5]  = '{1'b0, 4'b0000, 16'h1111, 1'b0, 1'b0, 4'b0000, 2'd0};
        // requester 0 weight 3, all requesting
        vecs[6]  = '{1'b1, 4'b0000, 16'h1113, 1'b0, 1'b0, 4'b0000, 2'd0};
        vecs[7]  = '{1'b0, 4'b1111, 16'h1113, 1'b1, 1'b1, 4'b0001, 2'd0};
        vecs[8]  = '{1'b0, 4'b1111, 16'h1113, 1'b1, 1'b1, 4'b0001, 2'd0};
        vecs[9]  = '{1'b0, 4'b1111, 16'h1113, 1'b1, 1'b1, 4'b0001, 2'd0};
        vecs[10] = '{1'b0, 4'b1111, 16'h1113, 1'b1, 1'b1, 4'b0010, 2'd1};
        vecs[11] = '{1'b0, 4'b1111, 16'h1113, 1'b1, 1'b1, 4'b0100, 2'd2};
        vecs[12] = '{1'b0, 4'b1111, 16'h1113, 1'b1, 1'b1, 4'b1000, 2'd3};
        vecs[13] = '{1'b0, 4'b1111, 16'h1113, 1'b1, 1'b1, 4'b0001, 2'd0};
        vecs[14] = '{1'b0, 4'b1111, 16'h1113, 1'b1, 1'b1, 4'b0001, 2'd0};
        vecs[15] = '{1'b0, 4'b1111, 16'h1113, 1'b1, 1'b1, 4'b0001, 2'd0};
        // weight 0 on requester 2, sole requester, then drop outside a burst
        vecs[16] = '{1'b1, 4'b0000, 16'h1011, 1'b0, 1'b0, 4'b0000, 2'd0};
        vecs[17] = '{1'b0, 4'b0100, 16'h1011, 1'b1, 1'b1, 4'b0100, 2'd2};
        vecs[18] = '{1'b0, 4'b0100, 16'h1011, 1'b1, 1'b1, 4'b0100, 2'd2};
        vecs[19] = '{1'b0, 4'b0100, 16'h1011, 1'b1, 1'b1, 4'b0100, 2'd2};
        vecs[20] = '{1'b0, 4'b0100, 16'h1011, 1'b1, 1'b1, 4'b0100, 2'd2};
        vecs[21] = '{1'b0, 4'b0000, 16'h1011, 1'b0, 1'b0, 4'b0000, 2'd0};

        for (int i = 0; i < 22; i++) begin
            i_weights = vecs[i].w;
            step(vecs[i].rst, vecs[i].req, vecs[i].ready, vecs[i].last);
            check($sformatf("vec%0d", i), vecs[i].exp_g, vecs[i].exp_idx);
        end

        // burst lock: requester 1 drops its request mid-burst while requester 0 competes
        i_weights = 16'h1111;
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        check("lock_reset", 4'b0000, 2'd0);
        step(1'b0, 4'b0010, 1'b0, 1'b0);
        check("lock_load", 4'b0010, 2'd1);
        step(1'b0, 4'b0010, 1'b1, 1'b0);
        check("lock_beat1", 4'b0010, 2'd1);
        step(1'b0, 4'b0010, 1'b1, 1'b0);
        check("lock_beat2", 4'b0010, 2'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'b0001, 1'b1, 1'b0);
            check($sformatf("lock_hold%0d", i), 4'b0010, 2'd1);
        end
        step(1'b0, 4'b0011, 1'b1, 1'b0);
        check("lock_beat3", 4'b0010, 2'd1);
        step(1'b0, 4'b0011, 1'b1, 1'b1);
        check("lock_release", 4'b0001, 2'd0);

        // reset mid-burst with requester 3 granted
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        step(1'b0, 4'b1000, 1'b0, 1'b0);
        check("rst_load3", 4'b1000, 2'd3);
        step(1'b0, 4'b1000, 1'b1, 1'b0);
        check("rst_inburst", 4'b1000, 2'd3);
        step(1'b1, 4'b1001, 1'b1, 1'b0);
        check("rst_mid", 4'b0000, 2'd0);
        step(1'b0, 4'b1001, 1'b0, 1'b0);
        check("rst_first", 4'b0001, 2'd0);

        // ready stalled for 10 cycles, requester 2 weight 2
        i_weights = 16'h1211;
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        step(1'b0, 4'b0100, 1'b0, 1'b0);
        check("stall_load", 4'b0100, 2'd2);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 4'b0110, 1'b0, 1'b0);
            check($sformatf("stall%0d", i), 4'b0100, 2'd2);
        end
        step(1'b0, 4'b0110, 1'b1, 1'b1);
        check("stall_burst1", 4'b0100, 2'd2);
        step(1'b0, 4'b0110, 1'b1, 1'b1);
        check("stall_handoff", 4'b0010, 2'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
